floating_point_multiply_pipe: RTL and testbench

Parametrised, fully pipelined IEEE-754-style floating-point multiplier. It is the successor to the fixed single-precision `floating_point_multiply`, and adds:
- configurable exponent and mantissa widths;
- downstream backpressure;
- a pass-through sideband tag;
- exception flags.

It sits between the accelerator's operand fetch and result write-back, and is driven and checked by the existing `file_driver`/`file_checker` benches.

---
 rtl/fp_pkg.sv | 40 ++++
 rtl/fp_unpack.sv | 45 ++++
 rtl/floating_point_multiply_pipe.sv | 230 +++++++++++++++++++++++
 tb/tb_floating_point_multiply_pipe.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the pipelined floating-point multiplier: the operand
// class encoding, the bit positions inside the flag vector, and helpers that
// derive format constants from the exponent/mantissa widths.
package fp_pkg;

    // Operand classification; subnormals are folded into ZERO.
    typedef enum logic [1:0] {
        ZERO   = 2'd0,
        NORMAL = 2'd1,
        INF    = 2'd2,
        NAN    = 2'd3
    } fp_class_t;

    // Bit positions within the 4-bit flag vector {invalid, overflow, underflow, inexact}.
    localparam int FLAG_INV = 3;
    localparam int FLAG_OVF = 2;
    localparam int FLAG_UNF = 1;
    localparam int FLAG_NX  = 0;

    // Widest word the qNaN helper can describe.
    localparam int FP_MAX_W = 64;

    // Exponent bias for an exp_w-bit exponent field.
    function automatic int fp_bias(input int exp_w);
        return (32'sd1 <<< (exp_w - 32'sd1)) - 32'sd1;
    endfunction

    // Canonical quiet NaN: sign 0, exponent all ones, mantissa MSB 1, rest 0.
    // Returned right-aligned in FP_MAX_W bits; the caller narrows it to its word.
    function automatic logic [FP_MAX_W-1:0] fp_qnan(input int exp_w, input int man_w);
        logic [FP_MAX_W-1:0] word;
        word = {FP_MAX_W{1'b0}};
        for (int i = 0; i < exp_w; i++) begin
            word[man_w + i] = 1'b1;
        end
        word[man_w - 1] = 1'b1;
        return word;
    endfunction

endpackage

// File: rtl/fp_unpack.sv
// Splits one operand into sign, exponent, significand with the implicit one,
// and its class. Subnormal inputs are reported as ZERO with a zero significand.
// For NaN the significand carries the raw mantissa so the caller can see its
// MSB (quiet/signalling).
module fp_unpack
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int W     = 1 + EXP_W + MAN_W
) (
    input  logic [W-1:0]     word,
    output logic             sign,
    output logic [EXP_W-1:0] exp,
    output logic [MAN_W:0]   sig,
    output logic [1:0]       cls
);

    logic [MAN_W-1:0] man_s;

    // Classify the operand from its exponent and mantissa fields.
    always_comb begin
        sign  = word[W-1];
        exp   = word[W-2:MAN_W];
        man_s = word[MAN_W-1:0];
        sig   = {(MAN_W+1){1'b0}};
        cls   = ZERO;
        if (exp == {EXP_W{1'b0}}) begin
            cls = ZERO;
            sig = {(MAN_W+1){1'b0}};
        end else if (&exp) begin
            if (man_s == {MAN_W{1'b0}}) begin
                cls = INF;
                sig = {(MAN_W+1){1'b0}};
            end else begin
                cls = NAN;
                sig = {1'b0, man_s};
            end
        end else begin
            cls = NORMAL;
            sig = {1'b1, man_s};
        end
    end

endmodule

// File: rtl/floating_point_multiply_pipe.sv
// Three-stage pipelined floating-point multiplier with a global stall.
//   S1: unpack both operands, add exponents, resolve special cases.
//   S2: multiply the significands.
//   S3: normalise, round to nearest even, detect range errors, pack; these are
//       the output registers.
// Every stage advances only when the output is free or being taken
// (advance = !validOut | readyIn), so a stalled output freezes the pipe.
module floating_point_multiply_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                         clkIn,
    input  logic                         rstIn,
    input  logic [EXP_W+MAN_W:0]         dataAIn,
    input  logic [EXP_W+MAN_W:0]         dataBIn,
    input  logic [TAG_W-1:0]             tagIn,
    input  logic                         validIn,
    output logic                         readyOut,
    output logic [EXP_W+MAN_W:0]         dataOut,
    output logic [TAG_W-1:0]             tagOut,
    output logic [3:0]                   flagsOut,
    output logic                         validOut,
    input  logic                         readyIn
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * MAN_W + 2;
    localparam int EW = EXP_W + 2;

    localparam logic [W-1:0]  QNAN     = W'(fp_qnan(EXP_W, MAN_W));
    localparam logic [EW-1:0] BIAS_E   = EW'(fp_bias(EXP_W));
    localparam logic [EW-1:0] EXP_MAX  = EW'((32'sd1 <<< EXP_W) - 32'sd1);

    logic advance_s;

    // Unpacked operands
    logic             sign_a_s, sign_b_s;
    logic [EXP_W-1:0] exp_a_s, exp_b_s;
    logic [MAN_W:0]   sig_a_s, sig_b_s;
    logic [1:0]       cls_a_s, cls_b_s;

    // Stage 1 combinational results
    logic             s1_sign_s;
    logic [EW-1:0]    s1_exp_s;
    logic             s1_special_s;
    logic [W-1:0]     s1_special_word_s;
    logic [3:0]       s1_special_flags_s;

    // Stage 1 registers
    logic             s1_valid_r;
    logic [TAG_W-1:0] s1_tag_r;
    logic             s1_sign_r;
    logic [EW-1:0]    s1_exp_r;
    logic             s1_special_r;
    logic [W-1:0]     s1_special_word_r;
    logic [3:0]       s1_special_flags_r;
    logic [MAN_W:0]   s1_sig_a_r, s1_sig_b_r;

    // Stage 2 registers
    logic             s2_valid_r;
    logic [TAG_W-1:0] s2_tag_r;
    logic             s2_sign_r;
    logic [EW-1:0]    s2_exp_r;
    logic             s2_special_r;
    logic [W-1:0]     s2_special_word_r;
    logic [3:0]       s2_special_flags_r;
    logic [PW-1:0]    s2_prod_r;
    logic [PW-1:0]    prod_s;

    // Stage 3 combinational results
    logic             norm_s;
    logic [PW-2:0]    shifted_s;
    logic [MAN_W-1:0] man_trunc_s;
    logic             guard_s, sticky_s, round_up_s;
    logic [MAN_W:0]   man_rnd_s;
    logic [EW-1:0]    exp_rnd_s;
    logic [W-1:0]     result_s;
    logic [3:0]       flags_s;

    // Pipeline moves when the output slot is empty or is being consumed.
    always_comb begin
        advance_s = !validOut || readyIn;
        readyOut  = advance_s;
    end

    fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W), .W(W)) u_unpack_a (
        .word (dataAIn),
        .sign (sign_a_s),
        .exp  (exp_a_s),
        .sig  (sig_a_s),
        .cls  (cls_a_s)
    );

    fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W), .W(W)) u_unpack_b (
        .word (dataBIn),
        .sign (sign_b_s),
        .exp  (exp_b_s),
        .sig  (sig_b_s),
        .cls  (cls_b_s)
    );

    // S1: sum the biased exponents and pick a special-case result by priority.
    always_comb begin
        s1_sign_s          = sign_a_s ^ sign_b_s;
        s1_exp_s           = {2'b00, exp_a_s} + {2'b00, exp_b_s} - BIAS_E;
        s1_special_s       = 1'b1;
        s1_special_word_s  = {W{1'b0}};
        s1_special_flags_s = 4'b0000;
        if ((cls_a_s == NAN) || (cls_b_s == NAN)) begin
            // Signalling NaN has a clear mantissa MSB.
            s1_special_word_s = QNAN;
            s1_special_flags_s[FLAG_INV] = ((cls_a_s == NAN) && !sig_a_s[MAN_W-1]) ||
                                           ((cls_b_s == NAN) && !sig_b_s[MAN_W-1]);
        end else if (((cls_a_s == INF) && (cls_b_s == ZERO)) ||
                     ((cls_a_s == ZERO) && (cls_b_s == INF))) begin
            s1_special_word_s = QNAN;
            s1_special_flags_s[FLAG_INV] = 1'b1;
        end else if ((cls_a_s == INF) || (cls_b_s == INF)) begin
            s1_special_word_s = {s1_sign_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if ((cls_a_s == ZERO) || (cls_b_s == ZERO)) begin
            s1_special_word_s = {s1_sign_s, {(W-1){1'b0}}};
        end else begin
            s1_special_s = 1'b0;
        end
    end

    // S1 register: capture the accepted operation.
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            s1_valid_r         <= 1'b0;
            s1_tag_r           <= {TAG_W{1'b0}};
            s1_sign_r          <= 1'b0;
            s1_exp_r           <= {EW{1'b0}};
            s1_special_r       <= 1'b0;
            s1_special_word_r  <= {W{1'b0}};
            s1_special_flags_r <= 4'b0000;
            s1_sig_a_r         <= {(MAN_W+1){1'b0}};
            s1_sig_b_r         <= {(MAN_W+1){1'b0}};
        end else if (advance_s) begin
            s1_valid_r         <= validIn;
            s1_tag_r           <= tagIn;
            s1_sign_r          <= s1_sign_s;
            s1_exp_r           <= s1_exp_s;
            s1_special_r       <= s1_special_s;
            s1_special_word_r  <= s1_special_word_s;
            s1_special_flags_r <= s1_special_flags_s;
            s1_sig_a_r         <= sig_a_s;
            s1_sig_b_r         <= sig_b_s;
        end
    end

    // S2: full-width significand product.
    always_comb begin
        prod_s = {{(MAN_W+1){1'b0}}, s1_sig_a_r} * {{(MAN_W+1){1'b0}}, s1_sig_b_r};
    end

    // S2 register: product plus the fields carried alongside it.
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            s2_valid_r         <= 1'b0;
            s2_tag_r           <= {TAG_W{1'b0}};
            s2_sign_r          <= 1'b0;
            s2_exp_r           <= {EW{1'b0}};
            s2_special_r       <= 1'b0;
            s2_special_word_r  <= {W{1'b0}};
            s2_special_flags_r <= 4'b0000;
            s2_prod_r          <= {PW{1'b0}};
        end else if (advance_s) begin
            s2_valid_r         <= s1_valid_r;
            s2_tag_r           <= s1_tag_r;
            s2_sign_r          <= s1_sign_r;
            s2_exp_r           <= s1_exp_r;
            s2_special_r       <= s1_special_r;
            s2_special_word_r  <= s1_special_word_r;
            s2_special_flags_r <= s1_special_flags_r;
            s2_prod_r          <= prod_s;
        end
    end

    // S3: normalise, round to nearest even, range-check and pack.
    always_comb begin
        // Product of two [1,2) values lies in [1,4); the MSB says which half.
        norm_s      = s2_prod_r[PW-1];
        shifted_s   = norm_s ? s2_prod_r[PW-2:0] : {s2_prod_r[PW-3:0], 1'b0};
        man_trunc_s = shifted_s[PW-2 -: MAN_W];
        guard_s     = shifted_s[MAN_W];
        sticky_s    = |shifted_s[MAN_W-1:0];
        round_up_s  = guard_s && (sticky_s || man_trunc_s[0]);
        // A carry out of the mantissa leaves the stored field at zero, so only
        // the exponent needs bumping.
        man_rnd_s   = {1'b0, man_trunc_s} + {{MAN_W{1'b0}}, round_up_s};
        exp_rnd_s   = s2_exp_r + {{(EW-1){1'b0}}, norm_s} + {{(EW-1){1'b0}}, man_rnd_s[MAN_W]};
        result_s    = {W{1'b0}};
        flags_s     = 4'b0000;
        if (s2_special_r) begin
            result_s = s2_special_word_r;
            flags_s  = s2_special_flags_r;
        end else if (!exp_rnd_s[EW-1] && (exp_rnd_s >= EXP_MAX)) begin
            result_s = {s2_sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_s[FLAG_OVF] = 1'b1;
            flags_s[FLAG_NX]  = 1'b1;
        end else if (exp_rnd_s[EW-1] || (exp_rnd_s == {EW{1'b0}})) begin
            result_s = {s2_sign_r, {(W-1){1'b0}}};
            flags_s[FLAG_UNF] = 1'b1;
            flags_s[FLAG_NX]  = 1'b1;
        end else begin
            result_s = {s2_sign_r, exp_rnd_s[EXP_W-1:0], man_rnd_s[MAN_W-1:0]};
            flags_s[FLAG_NX] = guard_s || sticky_s;
        end
    end

    // S3 / output registers: frozen while the result waits for readyIn.
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            validOut <= 1'b0;
            dataOut  <= {W{1'b0}};
            tagOut   <= {TAG_W{1'b0}};
            flagsOut <= 4'b0000;
        end else if (advance_s) begin
            validOut <= s2_valid_r;
            dataOut  <= s2_valid_r ? result_s : {W{1'b0}};
            tagOut   <= s2_valid_r ? s2_tag_r : {TAG_W{1'b0}};
            flagsOut <= s2_valid_r ? flags_s  : 4'b0000;
        end
    end

endmodule

// File: tb/tb_floating_point_multiply_pipe.sv
// Scoreboard bench for floating_point_multiply_pipe. Stimulus pushes expected
// {tag, flags, data} entries; an independent monitor pops and compares on each
// output handshake and checks hold/ready behaviour. A small FP16 instance
// covers the parametrised build.
module tb_floating_point_multiply_pipe;

    logic        clkIn = 1'b0;
    logic        rstIn;
    logic [31:0] dataAIn, dataBIn;
    logic [3:0]  tagIn;
    logic        validIn;
    logic        readyOut;
    logic [31:0] dataOut;
    logic [3:0]  tagOut;
    logic [3:0]  flagsOut;
    logic        validOut;
    logic        readyIn;

    logic [15:0] a16, b16, data16;
    logic [3:0]  tag16_in, tag16_out, flags16;
    logic        valid16_in, ready16_out, valid16_out, ready16_in;

    int tests = 0;
    int fails = 0;
    int pop_cnt = 0;
    bit mon_en = 1'b0;
    bit saw_ready_low = 1'b0;
    int mode = 0;
    int rel = 0;
    logic [39:0] exp_q[$];

    always #5 clkIn = ~clkIn;

    floating_point_multiply_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
        .clkIn(clkIn), .rstIn(rstIn), .dataAIn(dataAIn), .dataBIn(dataBIn),
        .tagIn(tagIn), .validIn(validIn), .readyOut(readyOut), .dataOut(dataOut),
        .tagOut(tagOut), .flagsOut(flagsOut), .validOut(validOut), .readyIn(readyIn)
    );

    floating_point_multiply_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) dut16 (
        .clkIn(clkIn), .rstIn(rstIn), .dataAIn(a16), .dataBIn(b16),
        .tagIn(tag16_in), .validIn(valid16_in), .readyOut(ready16_out), .dataOut(data16),
        .tagOut(tag16_out), .flagsOut(flags16), .validOut(valid16_out), .readyIn(ready16_in)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference FP32 multiply from the arithmetic rules; returns {flags, data}.
    function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic [7:0] ea, eb;
        logic [22:0] ma, mb;
        logic s, a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero, nx;
        longint unsigned p, q, rem, half;
        int e, sh;
        ea = a[30:23]; eb = b[30:23]; ma = a[22:0]; mb = b[22:0];
        s = a[31] ^ b[31];
        a_nan = (ea == 8'hFF) && (ma != 23'd0);
        b_nan = (eb == 8'hFF) && (mb != 23'd0);
        a_snan = a_nan && !ma[22];
        b_snan = b_nan && !mb[22];
        a_inf = (ea == 8'hFF) && (ma == 23'd0);
        b_inf = (eb == 8'hFF) && (mb == 23'd0);
        a_zero = (ea == 8'd0);
        b_zero = (eb == 8'd0);
        if (a_nan || b_nan) return {(a_snan || b_snan) ? 4'b1000 : 4'b0000, 32'h7FC00000};
        if ((a_inf && b_zero) || (a_zero && b_inf)) return {4'b1000, 32'h7FC00000};
        if (a_inf || b_inf) return {4'b0000, s, 8'hFF, 23'd0};
        if (a_zero || b_zero) return {4'b0000, s, 31'd0};
        p = longint'({1'b1, ma}) * longint'({1'b1, mb});
        e = int'(ea) + int'(eb) - 127;
        if (p >= (64'd1 << 47)) begin sh = 24; e = e + 1; end
        else sh = 23;
        q = p >> sh;
        rem = p - (q << sh);
        half = 64'd1 << (sh - 1);
        nx = (rem != 64'd0);
        if ((rem > half) || ((rem == half) && q[0])) q = q + 64'd1;
        if (q == (64'd1 << 24)) begin q = q >> 1; e = e + 1; end
        if (e >= 255) return {4'b0101, s, 8'hFF, 23'd0};
        if (e <= 0) return {4'b0011, s, 31'd0};
        return {3'b000, nx, s, e[7:0], q[22:0]};
    endfunction

    function automatic logic [31:0] gen_operand();
        logic [22:0] m;
        logic [7:0] e;
        int kind;
        kind = int'($urandom_range(0, 15));
        m = 23'($urandom);
        case (kind)
            0: e = 8'd0;
            1: begin e = 8'hFF; m = 23'd0; end
            2: begin e = 8'hFF; if (m == 23'd0) m = 23'd1; end
            3: e = 8'($urandom_range(190, 254));
            4: e = 8'($urandom_range(1, 64));
            5: begin e = 8'($urandom_range(100, 150)); m = 23'h7FFFFF - 23'($urandom_range(0, 7)); end
            default: e = 8'($urandom_range(100, 154));
        endcase
        return {1'($urandom_range(0, 1)), e, m};
    endfunction

    // Advance to just after the next rising edge and set readyIn for the new cycle.
    task automatic cycle();
        @(posedge clkIn);
        #1;
        rel++;
        case (mode)
            0: readyIn = 1'b1;
            1: readyIn = ($urandom_range(0, 3) != 0);
            2: readyIn = !((rel >= 4) && (rel <= 9));
            default: readyIn = 1'b1;
        endcase
    endtask

    // Present an operation and hold it until accepted; record its expectation.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                         input logic [35:0] expv);
        bit acc;
        acc = 1'b0;
        validIn = 1'b1; dataAIn = a; dataBIn = b; tagIn = tag;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clkIn);
            if (readyOut && !rstIn) begin
                acc = 1'b1;
                exp_q.push_back({tag, expv});
            end
            cycle();
        end
        validIn = 1'b0;
        if (!acc) check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        for (int n = 0; n < 200 && exp_q.size() != 0; n++) cycle();
        if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
        cycle();
        cycle();
    endtask

    task automatic measure_latency(input string name);
        int lat;
        lat = 0;
        do begin
            @(negedge clkIn);
            lat++;
        end while (!validOut && lat < 20);
        check(name, 64'(lat), 64'd3);
    endtask

    // Monitor: pop and compare on every output transfer, check holding and readyOut.
    initial begin
        logic [39:0] held;
        logic [39:0] e;
        bit prev_stall;
        prev_stall = 1'b0;
        held = 40'd0;
        forever begin
            @(negedge clkIn);
            if (mon_en) begin
                if (rstIn) begin
                    prev_stall = 1'b0;
                end else begin
                    check("ready_rule", 64'(readyOut), 64'(!validOut || readyIn));
                    if (!readyOut) saw_ready_low = 1'b1;
                    if (prev_stall)
                        check("hold_stable", 64'({validOut, tagOut, flagsOut, dataOut}), 64'({1'b1, held}));
                    if (validOut && exp_q.size() == 0) begin
                        check("unexpected_output", 64'd1, 64'd0);
                    end else if (validOut && readyIn) begin
                        e = exp_q.pop_front();
                        pop_cnt++;
                        check("result", 64'({tagOut, flagsOut, dataOut}), 64'(e));
                    end
                    prev_stall = validOut && !readyIn;
                    held = {tagOut, flagsOut, dataOut};
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        int base, lat;
        rstIn = 1'b1; validIn = 1'b0; readyIn = 1'b1;
        dataAIn = 32'd0; dataBIn = 32'd0; tagIn = 4'd0;
        a16 = 16'd0; b16 = 16'd0; tag16_in = 4'd0; valid16_in = 1'b0; ready16_in = 1'b1;
        repeat (2) @(posedge clkIn);
        #1 rstIn = 1'b0;
        @(negedge clkIn);
        check("rst_valid", 64'(validOut), 64'd0);
        check("rst_data", 64'(dataOut), 64'd0);
        check("rst_flags", 64'(flagsOut), 64'd0);
        check("rst_tag", 64'(tagOut), 64'd0);
        check("rst_ready", 64'(readyOut), 64'd1);
        check("rst_valid16", 64'(valid16_out), 64'd0);
        mon_en = 1'b1;
        cycle();

        // Basic product and latency
        mode = 0;
        issue(32'h3FC00000, 32'h40000000, 4'hA, {4'b0000, 32'h40400000});
        measure_latency("latency_basic");
        drain();

        // Directed special, range and rounding cases
        issue(32'h7F800000, 32'h00000000, 4'h1, {4'b1000, 32'h7FC00000});
        issue(32'h7F800001, 32'h3F800000, 4'h2, {4'b1000, 32'h7FC00000});
        issue(32'hFF800000, 32'h40000000, 4'h3, {4'b0000, 32'hFF800000});
        issue(32'h7F000000, 32'h7F000000, 4'h4, {4'b0101, 32'h7F800000});
        issue(32'h00800000, 32'h00800000, 4'h5, {4'b0011, 32'h00000000});
        issue(32'h00400000, 32'h3F800000, 4'h6, {4'b0000, 32'h00000000});
        issue(32'h3F800001, 32'h3F800001, 4'h7, {4'b0001, 32'h3F800002});
        issue(32'h7FC00000, 32'h7F800001, 4'h8, {4'b1000, 32'h7FC00000});
        issue(32'h80000000, 32'h3F800000, 4'h9, {4'b0000, 32'h80000000});
        drain();

        // FP16 build
        valid16_in = 1'b1; a16 = 16'h3C00; b16 = 16'h4000; tag16_in = 4'hC;
        @(negedge clkIn);
        check("fp16_ready", 64'(ready16_out), 64'd1);
        cycle();
        valid16_in = 1'b0;
        lat = 0;
        do begin @(negedge clkIn); lat++; end while (!valid16_out && lat < 20);
        check("fp16_latency", 64'(lat), 64'd3);
        check("fp16_data", 64'(data16), 64'h4000);
        check("fp16_flags", 64'(flags16), 64'd0);
        check("fp16_tag", 64'(tag16_out), 64'hC);
        drain();

        // Randomised traffic with random backpressure and idle gaps
        mode = 1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                cycle();
            end else begin
                a = gen_operand();
                b = gen_operand();
                issue(a, b, 4'($urandom), ref_mul(a, b));
            end
        end
        mode = 0;
        drain();

        // Backpressure window: readyIn low for stream cycles 4..9
        mode = 2; rel = 0; readyIn = 1'b1; saw_ready_low = 1'b0; base = pop_cnt;
        for (int i = 0; i < 8; i++) begin
            a = {1'b0, 8'($urandom_range(110, 140)), 23'($urandom)};
            b = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 140)), 23'($urandom)};
            issue(a, b, 4'(i), ref_mul(a, b));
        end
        mode = 0;
        drain();
        check("bp_count", 64'(pop_cnt - base), 64'd8);
        check("bp_ready_dropped", 64'(saw_ready_low), 64'd1);

        // Reset with three operations in flight
        mode = 0;
        issue(32'h40000000, 32'h40000000, 4'h1, ref_mul(32'h40000000, 32'h40000000));
        issue(32'h40400000, 32'h40000000, 4'h2, ref_mul(32'h40400000, 32'h40000000));
        issue(32'h40800000, 32'h40000000, 4'h3, ref_mul(32'h40800000, 32'h40000000));
        readyIn = 1'b0; rstIn = 1'b1;
        validIn = 1'b1; dataAIn = 32'h3F800000; dataBIn = 32'h3F800000; tagIn = 4'hF;
        @(posedge clkIn);
        #1;
        rstIn = 1'b0; readyIn = 1'b1; validIn = 1'b0;
        exp_q.delete();
        @(negedge clkIn);
        check("mid_rst_valid", 64'(validOut), 64'd0);
        check("mid_rst_data", 64'(dataOut), 64'd0);
        check("mid_rst_flags", 64'(flagsOut), 64'd0);
        check("mid_rst_tag", 64'(tagOut), 64'd0);
        check("mid_rst_ready", 64'(readyOut), 64'd1);
        repeat (5) cycle();
        issue(32'h40A00000, 32'hC0000000, 4'h6, {4'b0000, 32'hC1200000});
        measure_latency("latency_after_reset");
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
